nibble_serial_add_ctrl: RTL



---
 rtl/nibble_serial_add_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder sequencer time-sharing one external 4-bit slice, LS nibble first.
// Latency NIB+1 cycles accept-to-out_valid; holds in DONE while out_ready is low, no bypass.
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [3:0]       adder_a,
   output logic [3:0]       adder_b,
   output logic             adder_cin,
   input  logic [3:0]       adder_s,
   input  logic             adder_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic             carry_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] sum_nxt;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic             run;

   assign run       = (state == S_RUN);
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

   // Nibble select and partial-sum merge; idx never exceeds NIB-1 while in RUN.
   always_comb begin
      nib_a   = '0;
      nib_b   = '0;
      sum_nxt = sum_reg;
      for (int k = 0; k < NIB; k++) begin
         if (idx == IW'(k)) begin
            nib_a              = a_reg[4*k +: 4];
            nib_b              = b_reg[4*k +: 4];
            sum_nxt[4*k +: 4]  = adder_s;
         end
      end
   end

   assign adder_a   = run ? nib_a : 4'h0;
   assign adder_b   = run ? nib_b : 4'h0;
   assign adder_cin = run ? carry_reg : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg     <= in_a;
                  b_reg     <= in_b;
                  carry_reg <= in_cin;
                  idx       <= '0;
                  sum_reg   <= '0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               sum_reg   <= sum_nxt;
               carry_reg <= adder_cout;
               idx       <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  // Published result only changes here, so it survives DONE exit.
                  out_sum  <= sum_nxt;
                  out_cout <= adder_cout;
                  out_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                              (adder_s[3] != a_reg[WIDTH-1]);
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
